// File: rtl/avalon_aes_master.sv
`default_nettype none
// ============================================================================
// Module   : avalon_aes_master
// Purpose  : Hardware-only Avalon-MM initiator for the AES decryption
//            peripheral. Accepts a (key, ciphertext) job on a valid/ready
//            stream, loads the slave's key/ciphertext registers, sets START,
//            polls DONE, reads the plaintext back, clears START/DONE and
//            presents the plaintext on a valid/ready output stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n            clock (rising edge) / asynchronous active-low reset
//   i_in_valid/o_in_ready job handshake (ready only while idle)
//   i_in_key, i_in_msg_enc 128-bit key and ciphertext
//   o_out_valid/i_out_ready result handshake (valid held until ready)
//   o_out_msg_dec         128-bit plaintext
//   o_out_err             job aborted by poll timeout (qualified by valid)
//   o_avl_*               Avalon-MM read/write/cs/byte_en/addr/writedata
//   i_avl_readdata        read data, valid with read when waitrequest low
//   i_avl_waitrequest     slave stall
// Configuration
//   AES_MASTER_TIMEOUT_EN : when defined, POLL gives up after TIMEOUT_CYCLES
//                           reads without DONE and the job ends with
//                           o_out_err = 1. Undefined: polls forever, err = 0.
// ============================================================================
module avalon_aes_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_in_key,
  input  logic [127:0] i_in_msg_enc,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_msg_dec,
  output logic         o_out_err,
  output logic         o_avl_read,
  output logic         o_avl_write,
  output logic         o_avl_cs,
  output logic [3:0]   o_avl_byte_en,
  output logic [3:0]   o_avl_addr,
  output logic [31:0]  o_avl_writedata,
  input  logic [31:0]  i_avl_readdata,
  input  logic         i_avl_waitrequest
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_DATA  = 3'd1,
    S_WR_START = 3'd2,
    S_POLL     = 3'd3,
    S_RD_DEC   = 3'd4,
    S_WR_CLR   = 3'd5,
    S_OUT      = 3'd6
  } state_t;

  localparam logic [3:0] c_ADDR_START = 4'd14;
  localparam logic [3:0] c_ADDR_DONE  = 4'd15;

  state_t       r_state;
  state_t       w_state_nxt;
  logic [2:0]   r_beat;
  logic [2:0]   w_beat_nxt;
  logic [127:0] r_key;
  logic [127:0] r_msg;
  logic [127:0] r_dec;

  logic         w_xfer;
  logic         w_done;
  logic         w_abort;
  logic         w_rd;
  logic         w_wr;
  logic         w_cs;
  logic [3:0]   w_addr;
  logic [31:0]  w_wdata;
  logic         w_in_ready;
  logic         w_out_valid;

  // A transfer completes in the first cycle the slave does not stall.
  assign w_xfer = ~i_avl_waitrequest;
  assign w_done = i_avl_readdata[0];

  // Word k of a 128-bit value, most significant word first.
  function automatic logic [31:0] f_word(input logic [127:0] v, input logic [1:0] k);
    logic [127:0] t;
    t = v << {k, 5'b00000};
    return t[127:96];
  endfunction

`ifdef AES_MASTER_TIMEOUT_EN
  localparam int c_PW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [c_PW-1:0] c_POLL_LAST = c_PW'(TIMEOUT_CYCLES - 1);

  logic [c_PW-1:0] r_poll_cnt;
  logic            r_err;

  // Abort on the last allowed poll read if it still does not report DONE.
  assign w_abort = (r_state == S_POLL) && w_xfer && !w_done && (r_poll_cnt == c_POLL_LAST);

  // Counts completed poll reads; cleared whenever we are outside POLL so
  // every job starts with a fresh budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_poll_cnt <= '0;
    end else if (r_state != S_POLL) begin
      r_poll_cnt <= '0;
    end else if (w_xfer) begin
      r_poll_cnt <= r_poll_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((r_state == S_POLL) && w_xfer && w_done) begin
      r_err <= 1'b0;
    end else if (w_abort) begin
      r_err <= 1'b1;
    end
  end

  assign o_out_err = r_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_abort          = 1'b0;
  assign o_out_err        = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_beat  <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_beat  <= w_beat_nxt;
    end
  end

  // Next state and bus outputs. Bus outputs depend only on state and beat,
  // so they stay stable during a stall and drop as soon as reset asserts.
  always_comb begin
    w_state_nxt = r_state;
    w_beat_nxt  = r_beat;
    w_rd        = 1'b0;
    w_wr        = 1'b0;
    w_cs        = 1'b0;
    w_addr      = 4'd0;
    w_wdata     = 32'd0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (i_in_valid) begin
          w_state_nxt = S_WR_DATA;
          w_beat_nxt  = 3'd0;
        end
      end
      S_WR_DATA: begin
        w_cs    = 1'b1;
        w_wr    = 1'b1;
        w_addr  = {1'b0, r_beat};
        w_wdata = r_beat[2] ? f_word(r_msg, r_beat[1:0]) : f_word(r_key, r_beat[1:0]);
        if (w_xfer) begin
          if (r_beat == 3'd7) begin
            w_state_nxt = S_WR_START;
            w_beat_nxt  = 3'd0;
          end else begin
            w_beat_nxt = r_beat + 3'd1;
          end
        end
      end
      S_WR_START: begin
        w_cs    = 1'b1;
        w_wr    = 1'b1;
        w_addr  = c_ADDR_START;
        w_wdata = 32'd1;
        if (w_xfer) begin
          w_state_nxt = S_POLL;
        end
      end
      S_POLL: begin
        w_cs   = 1'b1;
        w_rd   = 1'b1;
        w_addr = c_ADDR_DONE;
        if (w_xfer && w_done) begin
          w_state_nxt = S_RD_DEC;
          w_beat_nxt  = 3'd0;
        end else if (w_abort) begin
          w_state_nxt = S_WR_CLR;
          w_beat_nxt  = 3'd0;
        end
      end
      S_RD_DEC: begin
        w_cs   = 1'b1;
        w_rd   = 1'b1;
        w_addr = {2'b10, r_beat[1:0]};
        if (w_xfer) begin
          if (r_beat == 3'd3) begin
            w_state_nxt = S_WR_CLR;
            w_beat_nxt  = 3'd0;
          end else begin
            w_beat_nxt = r_beat + 3'd1;
          end
        end
      end
      S_WR_CLR: begin
        // Beat 0 clears START, beat 1 clears DONE.
        w_cs    = 1'b1;
        w_wr    = 1'b1;
        w_addr  = r_beat[0] ? c_ADDR_DONE : c_ADDR_START;
        w_wdata = 32'd0;
        if (w_xfer && r_beat[0]) begin
          w_state_nxt = S_OUT;
          w_beat_nxt  = 3'd0;
        end else if (w_xfer) begin
          w_beat_nxt = r_beat + 3'd1;
        end
      end
      S_OUT: begin
        w_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_beat_nxt  = 3'd0;
      end
    endcase
  end

  // Job capture and plaintext assembly
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key <= '0;
      r_msg <= '0;
      r_dec <= '0;
    end else begin
      if ((r_state == S_IDLE) && i_in_valid) begin
        r_key <= i_in_key;
        r_msg <= i_in_msg_enc;
      end
      if ((r_state == S_RD_DEC) && w_xfer) begin
        case (r_beat[1:0])
          2'd0:    r_dec[127:96] <= i_avl_readdata;
          2'd1:    r_dec[95:64]  <= i_avl_readdata;
          2'd2:    r_dec[63:32]  <= i_avl_readdata;
          default: r_dec[31:0]   <= i_avl_readdata;
        endcase
      end
    end
  end

  assign o_in_ready      = w_in_ready;
  assign o_out_valid     = w_out_valid;
  assign o_out_msg_dec   = r_dec;
  assign o_avl_read      = w_rd;
  assign o_avl_write     = w_wr;
  assign o_avl_cs        = w_cs;
  assign o_avl_byte_en   = 4'hF;
  assign o_avl_addr      = w_addr;
  assign o_avl_writedata = w_wdata;

endmodule
`default_nettype wire

// File: tb/tb_avalon_aes_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_avalon_aes_master
// Purpose  : Scoreboard bench for avalon_aes_master. Contains a behavioural
//            AES slave (16-word register file with START/DONE and a known
//            answer for the FIPS-197 vector), wait-state injection, a
//            randomised job driver and a monitor that checks every bus
//            transfer, the output stream and the zero-wait latency.
//            Build with AES_MASTER_TIMEOUT_EN to include the timeout case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_avalon_aes_master;

  localparam int TB_TIMEOUT = 8;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_in_valid = 1'b0;
  logic         o_in_ready;
  logic [127:0] i_in_key = '0;
  logic [127:0] i_in_msg_enc = '0;
  logic         o_out_valid;
  logic         i_out_ready = 1'b0;
  logic [127:0] o_out_msg_dec;
  logic         o_out_err;
  logic         o_avl_read;
  logic         o_avl_write;
  logic         o_avl_cs;
  logic [3:0]   o_avl_byte_en;
  logic [3:0]   o_avl_addr;
  logic [31:0]  o_avl_writedata;
  logic [31:0]  i_avl_readdata;
  logic         i_avl_waitrequest;

  always #5 clk = ~clk;

  avalon_aes_master #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .i_in_valid        (i_in_valid),
    .o_in_ready        (o_in_ready),
    .i_in_key          (i_in_key),
    .i_in_msg_enc      (i_in_msg_enc),
    .o_out_valid       (o_out_valid),
    .i_out_ready       (i_out_ready),
    .o_out_msg_dec     (o_out_msg_dec),
    .o_out_err         (o_out_err),
    .o_avl_read        (o_avl_read),
    .o_avl_write       (o_avl_write),
    .o_avl_cs          (o_avl_cs),
    .o_avl_byte_en     (o_avl_byte_en),
    .o_avl_addr        (o_avl_addr),
    .o_avl_writedata   (o_avl_writedata),
    .i_avl_readdata    (i_avl_readdata),
    .i_avl_waitrequest (i_avl_waitrequest)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference decryption: the real answer for the FIPS vector, otherwise a
  // word-order-sensitive stand-in so mis-ordered words cannot cancel out.
  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] c);
    if (k == FIPS_KEY && c == FIPS_CT) return FIPS_PT;
    return k ^ {c[95:0], c[127:96]} ^ 128'h5a5a_0f0f_c3c3_9696_a5a5_f0f0_3c3c_6969;
  endfunction

  // ---------------- behavioural AES slave ----------------
  logic [31:0]  sregs [16] = '{default: 32'd0};
  int           p_target = 1;     // poll read number that first sees DONE
  int           s_polls = 0;
  bit           s_started = 1'b0;
  int           wmode = 0;        // 0 none, 1 directed stalls, 2 random
  int           stall_cnt = 0;
  int           rnd_tgt = 0;
  int           cur_tgt;
  logic         done_now;
  logic [127:0] w_slave_pt;

  always_comb begin
    done_now   = sregs[15][0] || (s_started && (s_polls + 1 >= p_target));
    w_slave_pt = aes_ref({sregs[0], sregs[1], sregs[2], sregs[3]},
                         {sregs[4], sregs[5], sregs[6], sregs[7]});
    i_avl_readdata = (o_avl_addr == 4'd15) ? {31'd0, done_now} : sregs[o_avl_addr];
    cur_tgt = 0;
    if (wmode == 1)
      cur_tgt = ((o_avl_write && o_avl_addr == 4'd1) || (o_avl_read && o_avl_addr == 4'd8)) ? 3 : 0;
    else if (wmode == 2)
      cur_tgt = rnd_tgt;
    i_avl_waitrequest = (o_avl_read || o_avl_write) && (stall_cnt < cur_tgt);
  end

  always @(posedge clk) begin
    if (o_avl_read || o_avl_write) begin
      if (i_avl_waitrequest) begin
        stall_cnt <= stall_cnt + 1;
      end else begin
        stall_cnt <= 0;
        rnd_tgt   <= int'($urandom_range(0, 2));
        if (o_avl_write) begin
          sregs[o_avl_addr] <= o_avl_writedata;
          if (o_avl_addr == 4'd14) begin
            if (o_avl_writedata[0]) begin
              s_started <= 1'b1;
              s_polls   <= 0;
              for (int j = 0; j < 4; j++) sregs[8+j] <= w_slave_pt[127-32*j -: 32];
            end else begin
              s_started <= 1'b0;
            end
          end
        end else if (o_avl_addr == 4'd15) begin
          s_polls <= s_polls + 1;
          if (done_now) sregs[15] <= 32'd1;
        end
      end
    end
  end

  // ---------------- scoreboard queues ----------------
  typedef struct {logic [127:0] pt; logic err;} out_t;
  typedef struct {logic wr; logic [3:0] addr; logic [31:0] data;} bus_t;
  out_t         exp_out[$];
  bus_t         exp_bus[$];
  logic [127:0] model_pt = '0;    // plaintext the output should be holding
  int           cyc = 0;
  int           acc_cyc = 0;
  int           hs_cyc = 0;
  bit           stalled = 1'b0;
  bit           b2b_pending = 1'b0;
  int           ready_delay = 0;

  task automatic push_expect(input logic [127:0] k, input logic [127:0] c);
    bit ab;
    ab = 1'b0;
`ifdef AES_MASTER_TIMEOUT_EN
    ab = (p_target > TB_TIMEOUT);
`endif
    if (!ab) model_pt = aes_ref(k, c);
    exp_out.push_back('{model_pt, ab});
    for (int j = 0; j < 4; j++) exp_bus.push_back('{1'b1, 4'(j), k[127-32*j -: 32]});
    for (int j = 0; j < 4; j++) exp_bus.push_back('{1'b1, 4'(4+j), c[127-32*j -: 32]});
    exp_bus.push_back('{1'b1, 4'd14, 32'd1});
    if (!ab) for (int j = 0; j < 4; j++) exp_bus.push_back('{1'b0, 4'(8+j), 32'd0});
    exp_bus.push_back('{1'b1, 4'd14, 32'd0});
    exp_bus.push_back('{1'b1, 4'd15, 32'd0});
  endtask

  // ---------------- monitor ----------------
  initial begin
    bit           prev_wait, prev_hold, prev_ov;
    logic [40:0]  prev_bus;
    logic [127:0] prev_dec;
    logic         prev_err;
    bus_t         e;
    out_t         o;
    prev_wait = 0; prev_hold = 0; prev_ov = 0; prev_bus = '0; prev_dec = '0; prev_err = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        prev_wait = 0; prev_hold = 0; prev_ov = 0;
        continue;
      end
      chk("byte_en", 128'(o_avl_byte_en), 128'hF);
      chk("rd_wr_excl", 128'(o_avl_read && o_avl_write), 128'd0);
      chk("cs_match", 128'(o_avl_cs), 128'(o_avl_read || o_avl_write));
      if (prev_wait)
        chk("stall_stable", 128'({o_avl_read, o_avl_write, o_avl_addr, o_avl_writedata, o_avl_cs}), 128'(prev_bus));
      if (i_avl_waitrequest) stalled = 1'b1;
      if ((o_avl_read || o_avl_write) && !i_avl_waitrequest && !(o_avl_read && o_avl_addr == 4'd15)) begin
        if (exp_bus.size() == 0) begin
          checks++; errors++;
          $display("FAIL bus_unexpected actual addr=%0d wr=%0b required none", o_avl_addr, o_avl_write);
        end else begin
          e = exp_bus.pop_front();
          chk("bus_xfer", {o_avl_write, o_avl_addr, o_avl_write ? o_avl_writedata : 32'd0},
              {e.wr, e.addr, e.data});
        end
      end
      if (i_in_valid && o_in_ready) begin
        acc_cyc = cyc;
        stalled = 1'b0;
        if (b2b_pending) begin
          chk("b2b_accept", 128'(cyc), 128'(hs_cyc + 1));
          b2b_pending = 1'b0;
        end
      end
      if (o_out_valid && !prev_ov && !stalled && exp_out.size() > 0)
        chk("latency", 128'(cyc - acc_cyc), 128'(exp_out[0].err ? 12 + s_polls : 16 + s_polls));
      if (prev_hold)
        chk("out_hold", {o_out_valid, o_out_err, o_out_msg_dec}, {1'b1, prev_err, prev_dec});
      if (o_out_valid && i_out_ready) begin
        hs_cyc = cyc;
        if (exp_out.size() == 0) begin
          checks++; errors++;
          $display("FAIL out_unexpected actual=%h required none", o_out_msg_dec);
        end else begin
          o = exp_out.pop_front();
          chk("out_dec", o_out_msg_dec, o.pt);
          chk("out_err", 128'(o_out_err), 128'(o.err));
          chk("slave_clr", {sregs[14], sregs[15]}, 128'd0);
        end
      end
      prev_wait = i_avl_waitrequest;
      prev_bus  = {o_avl_read, o_avl_write, o_avl_addr, o_avl_writedata, o_avl_cs};
      prev_hold = o_out_valid && !i_out_ready;
      prev_ov   = o_out_valid;
      prev_dec  = o_out_msg_dec;
      prev_err  = o_out_err;
    end
  end

  // ---------------- output consumer ----------------
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (o_out_valid) begin
        if (rcnt >= ready_delay) i_out_ready = 1'b1;
        else begin
          i_out_ready = 1'b0;
          rcnt++;
        end
      end else begin
        i_out_ready = 1'b0;
        rcnt = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send_job(input logic [127:0] k, input logic [127:0] c, input bit keep);
    bit acc;
    acc = 1'b0;
    i_in_key = k;
    i_in_msg_enc = c;
    i_in_valid = 1'b1;
    for (int n = 0; n < 3000 && !acc; n++) begin
      @(negedge clk);
      if (o_in_ready) acc = 1'b1;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_timeout actual ready=0 required ready=1");
    end else begin
      push_expect(k, c);
    end
    @(posedge clk);
    #1;
    if (!keep) i_in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 3000 && exp_out.size() > 0; n++) @(negedge clk);
    if (exp_out.size() > 0) begin
      checks++; errors++;
      $display("FAIL job_timeout actual pending=%0d required 0", exp_out.size());
      exp_out.delete();
      exp_bus.delete();
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk_reset_outputs(input string name);
    chk({name, "_ctl"}, 128'({o_in_ready, o_out_valid, o_out_err, o_avl_read, o_avl_write, o_avl_cs, o_avl_addr}),
        128'(10'b10_0000_0000));
    chk({name, "_wdata"}, 128'(o_avl_writedata), 128'd0);
    chk({name, "_dec"}, o_out_msg_dec, 128'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 vector, zero wait states
    wmode = 0; p_target = 3; ready_delay = 0;
    send_job(FIPS_KEY, FIPS_CT, 1'b0);
    wait_done();

    // DONE on the fifth poll: OUT_VALID 21 cycles after acceptance
    p_target = 5;
    send_job(rnd128(), rnd128(), 1'b0);
    wait_done();

    // stalls on the second key write and first plaintext read
    wmode = 1; p_target = 2;
    send_job(rnd128(), rnd128(), 1'b0);
    wait_done();
    wmode = 0;

    // consumer stalls 10 cycles; second job waits on IN_VALID
    ready_delay = 10; p_target = 1;
    send_job(rnd128(), rnd128(), 1'b1);
    b2b_pending = 1'b1;
    send_job(rnd128(), rnd128(), 1'b0);
    wait_done();
    ready_delay = 0;

    // randomised jobs with random wait states and consumer delay
    for (int i = 0; i < 6; i++) begin
      wmode = 2;
      p_target = int'($urandom_range(1, 4));
      ready_delay = int'($urandom_range(0, 3));
      send_job(rnd128(), rnd128(), 1'b0);
      wait_done();
    end
    wmode = 0; ready_delay = 0;

    // reset while polling
    p_target = 1000;
    send_job(rnd128(), rnd128(), 1'b0);
    for (int n = 0; n < 200 && s_polls < 2; n++) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    exp_out.delete();
    exp_bus.delete();
    model_pt = '0;
    b2b_pending = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    p_target = 2;
    send_job(rnd128(), rnd128(), 1'b0);
    wait_done();

`ifdef AES_MASTER_TIMEOUT_EN
    // DONE never set: abort after TB_TIMEOUT polls, plaintext unchanged
    p_target = 1000;
    send_job(rnd128(), rnd128(), 1'b0);
    wait_done();
    p_target = 1;
    send_job(rnd128(), rnd128(), 1'b0);
    wait_done();
`endif

    chk("bus_queue_empty", 128'(exp_bus.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
